// File: rtl/mc6502_serial_accumulator.sv
// mc6502_serial_accumulator
// Multi-byte 6502-style ADC/SBC engine. Processes one byte per clock, LSB
// first, and chains the carry between bytes. Produces N/Z/C/V for the whole
// word. Driven by an i_start / o_done handshake.
//
// Build option: define MC6502_DECIMAL_EN to build the BCD correction path.
// Without it, i_d is ignored and every operation is binary.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, waiting for i_start
// RUN   | one byte per edge, index r_k = 0 .. BYTES-1
// DONE  | result held on o_a/flags, new i_start accepted

module mc6502_serial_accumulator #(
  parameter int BYTES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [8*BYTES-1:0]   i_a,
  input  logic [8*BYTES-1:0]   i_m,
  input  logic                 i_c,
  input  logic                 i_d,
  input  logic                 i_s,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [8*BYTES-1:0]   o_a,
  output logic                 o_n,
  output logic                 o_z,
  output logic                 o_c,
  output logic                 o_v
);

  localparam int W  = 8 * BYTES;
  localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic            w_last;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_m;
  logic [W-1:0]    r_res;
  logic            r_c;
  logic            r_s;
  logic [KW-1:0]   r_k;

  logic [7:0]      w_op;
  logic [8:0]      w_bin;
  logic [7:0]      w_byte;
  logic            w_cout;
  logic            w_ovf;
  logic [W-1:0]    w_res_next;

`ifdef MC6502_DECIMAL_EN
  logic            r_d;
  logic [4:0]      w_lo;
  logic [4:0]      w_hi;
  logic            w_half;
`else
  logic            w_unused_d;
  assign w_unused_d = i_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode: start is only honoured outside RUN
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (r_k == K_LAST) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_busy = (r_state == RUN);

  // Per-byte adder: binary sum always formed, it also feeds the V flag
  always_comb begin
    w_op   = r_s ? ~r_m[7:0] : r_m[7:0];
    w_bin  = {1'b0, r_a[7:0]} + {1'b0, w_op} + {8'd0, r_c};
    w_byte = w_bin[7:0];
    w_cout = w_bin[8];
    w_ovf  = (r_a[7] == w_op[7]) && (w_bin[7] != r_a[7]);
`ifdef MC6502_DECIMAL_EN
    w_lo   = 5'd0;
    w_hi   = 5'd0;
    w_half = 1'b0;
    if (r_d) begin
      if (!r_s) begin
        // Nibble-wise decimal add; 5-bit sums keep the raw nibble carry
        w_lo   = {1'b0, r_a[3:0]} + {1'b0, r_m[3:0]} + {4'd0, r_c};
        w_half = (w_lo > 5'd9);
        w_hi   = {1'b0, r_a[7:4]} + {1'b0, r_m[7:4]} + {4'd0, w_half};
        w_cout = (w_hi > 5'd9);
        w_byte = {w_hi[3:0] + (w_cout ? 4'd6 : 4'd0),
                  w_lo[3:0] + (w_half ? 4'd6 : 4'd0)};
      end else begin
        // Decimal subtract corrects the binary difference per nibble;
        // carry stays the binary no-borrow
        w_lo   = {1'b0, r_a[3:0]} + {1'b0, ~r_m[3:0]} + {4'd0, r_c};
        w_half = ~w_lo[4];
        w_byte = {w_bin[7:4] - (w_bin[8] ? 4'd0 : 4'd6),
                  w_bin[3:0] - (w_half ? 4'd6 : 4'd0)};
      end
    end
`endif
  end

  // Result bytes enter at the top so byte 0 ends up at the bottom
  assign w_res_next = (r_res >> 8) | (W'(w_byte) << (W - 8));

  // Operand/result datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_m    <= '0;
      r_res  <= '0;
      r_c    <= 1'b0;
      r_s    <= 1'b0;
      r_k    <= '0;
      o_done <= 1'b0;
      o_a    <= '0;
      o_n    <= 1'b0;
      o_z    <= 1'b0;
      o_c    <= 1'b0;
      o_v    <= 1'b0;
`ifdef MC6502_DECIMAL_EN
      r_d    <= 1'b0;
`endif
    end else begin
      o_done <= w_last;
      if (w_accept) begin
        r_a   <= i_a;
        r_m   <= i_m;
        r_c   <= i_c;
        r_s   <= i_s;
        r_k   <= '0;
        r_res <= '0;
`ifdef MC6502_DECIMAL_EN
        r_d   <= i_d;
`endif
      end else if (r_state == RUN) begin
        r_a   <= r_a >> 8;
        r_m   <= r_m >> 8;
        r_c   <= w_cout;
        r_k   <= r_k + 1'b1;
        r_res <= w_res_next;
        if (w_last) begin
          o_a <= w_res_next;
          o_n <= w_res_next[W-1];
          o_z <= (w_res_next == '0);
          o_c <= w_cout;
          o_v <= w_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_mc6502_serial_accumulator.sv
// Directed bench for mc6502_serial_accumulator with BYTES=2.
// Decimal expectations follow MC6502_DECIMAL_EN when compiled together.

module tb_mc6502_serial_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [15:0] i_a;
  logic [15:0] i_m;
  logic        i_c;
  logic        i_d;
  logic        i_s;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_a;
  logic        o_n;
  logic        o_z;
  logic        o_c;
  logic        o_v;

  int n_pass  = 0;
  int n_total = 0;

  mc6502_serial_accumulator #(.BYTES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_a     (i_a),
    .i_m     (i_m),
    .i_c     (i_c),
    .i_d     (i_d),
    .i_s     (i_s),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_a     (o_a),
    .o_n     (o_n),
    .o_z     (o_z),
    .o_c     (o_c),
    .o_v     (o_v)
  );

  always #5 clk = ~clk;

  // Launches one operation and returns what was seen at o_done (lat = -1 on timeout)
  task automatic do_op(input logic [15:0] a, input logic [15:0] m,
                       input logic c, input logic d, input logic s,
                       output logic [15:0] ra, output logic [3:0] rf,
                       output int lat, output int bcnt);
    @(negedge clk);
    i_a = a; i_m = m; i_c = c; i_d = d; i_s = s; i_start = 1'b1;
    lat = -1; bcnt = 0; ra = 16'hxxxx; rf = 4'bxxxx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_busy) bcnt++;
      if (o_done) begin
        lat = i - 1;
        ra  = o_a;
        rf  = {o_n, o_z, o_c, o_v};
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; i_start = 1'b0; i_a = '0; i_m = '0; i_c = 0; i_d = 0; i_s = 0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({o_a, o_n, o_z, o_c, o_v, o_busy, o_done} !== 22'd0)
      $display("FAIL reset_outputs: got o_a=%h nzcv=%b busy=%b done=%b, want all 0",
               o_a, {o_n, o_z, o_c, o_v}, o_busy, o_done);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({o_busy, o_done} !== 2'b00)
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", o_busy, o_done);
    else n_pass++;
  endtask

  task automatic test_binary;
    logic [15:0] ra;
    logic [3:0]  rf;
    int lat, bcnt;
    logic [15:0] va [4] = '{16'h00FF, 16'h7FFF, 16'h0005, 16'h0001};
    logic [15:0] vm [4] = '{16'h0001, 16'h0001, 16'h0006, 16'hFFFF};
    logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] er [4] = '{16'h0100, 16'h8000, 16'hFFFF, 16'h0000};
    logic [3:0]  ef [4] = '{4'b0000, 4'b1001, 4'b1000, 4'b0110};
    for (int k = 0; k < 4; k++) begin
      do_op(va[k], vm[k], vc[k], 1'b0, vs[k], ra, rf, lat, bcnt);
      n_total++;
      if (ra !== er[k])
        $display("FAIL bin_result[%0d]: got %h, want %h", k, ra, er[k]);
      else n_pass++;
      n_total++;
      if (rf !== ef[k])
        $display("FAIL bin_flags[%0d]: got nzcv=%b, want %b", k, rf, ef[k]);
      else n_pass++;
      if (k == 0) begin
        n_total++;
        if (lat !== 2) $display("FAIL latency: got %0d edges, want 2", lat);
        else n_pass++;
        n_total++;
        if (bcnt !== 2) $display("FAIL busy_cycles: got %0d, want 2", bcnt);
        else n_pass++;
      end
    end
    @(negedge clk);
    n_total++;
    if (o_done !== 1'b0 || o_a !== 16'h0000)
      $display("FAIL done_one_cycle: got done=%b o_a=%h, want 0 and 0000", o_done, o_a);
    else n_pass++;
  endtask

  task automatic test_decimal;
    logic [15:0] ra;
    logic [3:0]  rf;
    int lat, bcnt;
`ifdef MC6502_DECIMAL_EN
    logic [15:0] e1 = 16'h7400;
    logic [15:0] e2 = 16'h0999;
`else
    logic [15:0] e1 = 16'h6D9A;
    logic [15:0] e2 = 16'h0FFF;
`endif
    do_op(16'h4499, 16'h2901, 1'b0, 1'b1, 1'b0, ra, rf, lat, bcnt);
    n_total++;
    if (ra !== e1) $display("FAIL dec_add_result: got %h, want %h", ra, e1);
    else n_pass++;
    n_total++;
    if (rf !== 4'b0000) $display("FAIL dec_add_flags: got nzcv=%b, want 0000", rf);
    else n_pass++;
    do_op(16'h1000, 16'h0001, 1'b1, 1'b1, 1'b1, ra, rf, lat, bcnt);
    n_total++;
    if (ra !== e2) $display("FAIL dec_sub_result: got %h, want %h", ra, e2);
    else n_pass++;
    n_total++;
    if (rf !== 4'b0010) $display("FAIL dec_sub_flags: got nzcv=%b, want 0010", rf);
    else n_pass++;
  endtask

  task automatic test_ignore_start;
    logic [15:0] prev;
    int seen;
    prev = o_a;
    @(negedge clk);
    i_a = 16'h00FF; i_m = 16'h0001; i_c = 0; i_d = 0; i_s = 0; i_start = 1'b1;
    @(negedge clk);
    i_a = 16'h1234; i_m = 16'h1111; i_s = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n_total++;
    if (o_done !== 1'b0 || o_a !== prev)
      $display("FAIL hold_during_run: got done=%b o_a=%h, want 0 and %h", o_done, o_a, prev);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (o_done !== 1'b1 || o_a !== 16'h0100)
      $display("FAIL ignore_start_result: got done=%b o_a=%h, want 1 and 0100", o_done, o_a);
    else n_pass++;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_done || o_busy) seen++;
    end
    n_total++;
    if (seen !== 0) $display("FAIL ignore_start_no_restart: got %0d active cycles, want 0", seen);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    i_a = 16'h7FFF; i_m = 16'h0001; i_c = 0; i_d = 0; i_s = 0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({o_a, o_n, o_z, o_c, o_v, o_busy, o_done} !== 22'd0)
      $display("FAIL mid_reset_outputs: got o_a=%h nzcv=%b busy=%b done=%b, want all 0",
               o_a, {o_n, o_z, o_c, o_v}, o_busy, o_done);
    else n_pass++;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_done || o_busy) seen++;
    end
    n_total++;
    if (seen !== 0 || o_a !== 16'h0000)
      $display("FAIL mid_reset_no_done: got %0d active cycles o_a=%h, want 0 and 0000", seen, o_a);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int ndone, last_i, bad_gap, bad_val;
    @(negedge clk);
    i_a = 16'h0001; i_m = 16'h0001; i_c = 0; i_d = 0; i_s = 0; i_start = 1'b1;
    ndone = 0; last_i = 0; bad_gap = 0; bad_val = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (o_done) begin
        ndone++;
        if (i - last_i != 3) bad_gap++;
        if (o_a !== 16'h0002) bad_val++;
        last_i = i;
      end
    end
    i_start = 1'b0;
    n_total++;
    if (ndone !== 3) $display("FAIL b2b_done_count: got %0d, want 3", ndone);
    else n_pass++;
    n_total++;
    if (bad_gap !== 0 || bad_val !== 0)
      $display("FAIL b2b_spacing: got %0d bad gaps %0d bad results, want 0 0", bad_gap, bad_val);
    else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_binary;
    test_decimal;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc6502_serial_accumulator.md
# mc6502_serial_accumulator

Sequential, width-parametrised successor to the single-byte combinational ADC/SBC accumulator. It performs multi-byte binary or BCD add/subtract-with-carry over `BYTES`-wide operands, one byte per clock, LSB first, chaining carry between bytes. It produces 6502-style N/Z/C/V flags for the whole word. It sits beside the core datapath for wide arithmetic helpers and is driven by a start/done handshake.

## Interface
- `BYTES`, default 2: operand width in bytes, ≥1; word width W = 8*BYTES.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  request; accepted only in IDLE or DONE.
- `i_a`  in  W  accumulator operand, sampled on the accepting edge.
- `i_m`  in  W  memory operand, sampled on the accepting edge.
- `i_c`  in  1  carry in; for subtract, 1 = no borrow.
- `i_d`  in  1  decimal (BCD) mode, sampled on the accepting edge.
- `i_s`  in  1  1 = subtract (SBC), 0 = add (ADC), sampled on the accepting edge.
- `o_busy`  out  1  high in RUN.
- `o_done`  out  1  one-cycle pulse when the result is valid.
- `o_a`  out  W  result, held until the next accepted start.
- `o_n`, `o_z`, `o_c`, `o_v`  out  1 each  flags, held with `o_a`.

## Operation
- States:
  - IDLE: after reset.
  - RUN: processing bytes.
  - DONE: result held.
- IDLE/DONE + `i_start`:
  - Latch operands, mode and carry.
  - Clear byte index to 0 and go to RUN.
  - `o_a` and flags keep their old values until the new result is complete.
- RUN: each edge processes byte index k.
  - Add: sum = A[k] + M[k] + carry.
  - Subtract: sum = A[k] + ~M[k] + carry.
  - Store the result byte into an internal shift register and pass the carry out to byte k+1.
  - k wraps nothing: at k = BYTES-1, go to DONE, copy the result to `o_a`, update flags, pulse `o_done`.
- DONE: outputs held. A new `i_start` is accepted; back-to-back starts give one result every BYTES+1 edges.
- `i_start` in RUN is ignored and has no side effects.
- Binary byte: 9-bit sum; carry out = bit 8.
- Decimal byte (add), computed per nibble:
  - Low nibble: if >9 or half-carry, add 6 and carry into the high nibble.
  - High nibble: if >9 or carry, add 6 (0x60) and set byte carry.
- Decimal byte (subtract):
  - Low nibble: subtract 6 when the low nibble borrowed.
  - High nibble: subtract 0x60 when the byte borrowed.
  - Carry = no-borrow.
- Non-BCD operand digits in decimal mode give an undefined result but must not hang the FSM.
- Flags, computed on the full W-bit corrected result:
  - N = `o_a`[W-1].
  - Z = (`o_a` == 0).
  - C = final byte carry.
  - V = signed overflow of the top byte's binary sum (A[top], operand-or-complement[top], binary sum[top]), in both modes.
- Reset, including mid-operation: go to IDLE; `o_a`=0, all flags 0, `o_busy`=0, `o_done`=0. A partial result is discarded and no `o_done` is issued.

## Timing
- Start accepted on edge E0; bytes processed on edges E1..E(BYTES).
- `o_busy` is high from after E0 through E(BYTES).
- `o_done` is high for exactly the cycle after E(BYTES), together with the new `o_a` and flags.
- Latency: BYTES edges from the accepting edge to `o_done`.
- `i_start` held high continuously in DONE restarts on that same edge; `o_done` still lasts one cycle.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MC6502_DECIMAL_EN` defined: BCD correction logic is built and `i_d` is honoured as above.
- `MC6502_DECIMAL_EN` undefined: no BCD logic; `i_d` is ignored and all operations are binary. Flags and timing are unchanged.

## Test plan
All scenarios use BYTES=2.
- Binary add: A=0x00FF, M=0x0001, c=0 → `o_a`=0x0100, N0 Z0 C0 V0. `o_done` 2 edges after start; `o_busy` high 2 cycles.
- Signed overflow: A=0x7FFF, M=0x0001, c=0 → 0x8000, N1 Z0 C0 V1.
- Binary subtract: s=1, A=0x0005, M=0x0006, c=1 → 0xFFFF, N1 Z0 C0 V0.
- Zero and carry: A=0x0001, M=0xFFFF, c=0 → 0x0000, Z1 C1 N0 V0.
- Decimal (macro defined):
  - d=1, A=0x4499, M=0x2901, c=0 → 0x7400, C0 N0 Z0 V0.
  - d=1, s=1, A=0x1000, M=0x0001, c=1 → 0x0999, C1 N0 V0.
  - Macro undefined, first vector → 0x6D9A.
- Control:
  - Pulse `i_start` during RUN → ignored, the original result still arrives on schedule.
  - Assert `rst` on E1 → IDLE, all outputs 0, no `o_done`.
  - Back-to-back starts → one `o_done` every 3 cycles.
